// File: rtl/tx_stripe_pkg.sv
// Shared types and helpers for the transmit lane striper.
package tx_stripe_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;

  localparam logic [1:0] LM_X1 = 2'd0;
  localparam logic [1:0] LM_X2 = 2'd1;
  localparam logic [1:0] LM_X4 = 2'd2;
  localparam logic [1:0] LM_X8 = 2'd3;

  localparam logic [7:0] PAD_BYTE_DEF = 8'hF7;

  // Requested lane count, clamped to the lanes physically present.
  function automatic int lanes_for_mode(input logic [1:0] mode, input int max_lanes);
    int n;
    case (mode)
      LM_X1:   n = 1;
      LM_X2:   n = 2;
      LM_X4:   n = 4;
      default: n = 8;
    endcase
    return (n > max_lanes) ? max_lanes : n;
  endfunction

endpackage

// File: rtl/tx_lane_serializer.sv
// One lane: DATA_W shift register plus valid flag, driven by the shared striper FSM.
// Bit order: LSB first, or MSB first when TXS_MSB_FIRST_EN is defined.
module tx_lane_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_bit,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_sr;
  logic              r_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr    <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_sr    <= i_data;
      r_valid <= 1'b1;
    end else if (i_clear) begin
      r_sr    <= '0;
      r_valid <= 1'b0;
    end else if (i_shift) begin
`ifdef TXS_MSB_FIRST_EN
      r_sr <= r_sr << 1;
`else
      r_sr <= r_sr >> 1;
`endif
    end
  end

`ifdef TXS_MSB_FIRST_EN
  assign o_bit = r_valid & r_sr[DATA_W-1];
`else
  assign o_bit = r_valid & r_sr[0];
`endif
  assign o_valid = r_valid;

endmodule

// File: rtl/tx_lane_striper.sv
// Round-robin byte striper over 1..NUM_LANES aligned serial lanes.
// Optional TXS_MSB_FIRST_EN switches every lane to MSB-first serialization.
module tx_lane_striper
  import tx_stripe_pkg::*;
#(
  parameter int                NUM_LANES = 4,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] PAD_BYTE  = DATA_W'(PAD_BYTE_DEF)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic [1:0]           lane_mode,
  output logic [NUM_LANES-1:0] lane_data,
  output logic [NUM_LANES-1:0] lane_valid,
  output logic                 busy
);

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int ACT_W = $clog2(NUM_LANES) + 1;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [IDX_W-1:0]  r_idx;
  logic [ACT_W-1:0]  r_act;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_hold [NUM_LANES];
  ser_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;

  logic             w_accept, w_flush, w_mode_ld, w_last_slot;
  logic             w_last_bit, w_load, w_group_done;
  logic [ACT_W-1:0] w_act;

  assign in_ready = reset & ~r_hold_full;
  assign w_accept = in_valid & in_ready;

  // A new mode only takes hold on an empty, drained striper; a byte accepted
  // on that same edge already belongs to a group of the new width.
  assign w_mode_ld   = (r_idx == '0) & ~r_hold_full & (r_state == IDLE);
  assign w_act       = w_mode_ld ? ACT_W'(lanes_for_mode(lane_mode, NUM_LANES)) : r_act;
  assign w_last_slot = (ACT_W'(r_idx) == (w_act - ACT_W'(1)));
  assign w_flush     = flush & ~r_hold_full & ((r_idx != '0) | w_accept);

  assign w_last_bit   = (r_bit_cnt == CNT_W'(DATA_W - 1));
  assign w_load       = r_hold_full & ((r_state == IDLE) | ((r_state == SHIFT) & w_last_bit));
  assign w_group_done = (r_state == SHIFT) & w_last_bit & ~r_hold_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx       <= '0;
      r_hold_full <= 1'b0;
      r_act       <= ACT_W'(lanes_for_mode(LM_X1, NUM_LANES));
      for (int i = 0; i < NUM_LANES; i++) r_hold[i] <= '0;
    end else begin
      if (w_mode_ld) r_act <= w_act;
      if (w_accept) r_hold[r_idx] <= in_data;
      if (w_flush) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if ((i < int'(w_act)) &&
              ((i > int'(r_idx)) || (!w_accept && (i == int'(r_idx)))))
            r_hold[i] <= PAD_BYTE;
        end
        r_hold_full <= 1'b1;
        r_idx       <= '0;
      end else if (w_accept) begin
        if (w_last_slot) begin
          r_hold_full <= 1'b1;
          r_idx       <= '0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_state_nxt   = SHIFT;
          w_bit_cnt_nxt = '0;
        end
      end
      SHIFT: begin
        if (w_load) begin
          w_bit_cnt_nxt = '0;
        end else if (w_last_bit) begin
          w_state_nxt   = IDLE;
          w_bit_cnt_nxt = '0;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic w_lane_on;
    assign w_lane_on = (g < int'(r_act));

    tx_lane_serializer #(.DATA_W(DATA_W)) u_ser (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load & w_lane_on),
      .i_clear ((w_load & ~w_lane_on) | w_group_done),
      .i_shift ((r_state == SHIFT) & ~w_load),
      .i_data  (r_hold[g]),
      .o_bit   (lane_data[g]),
      .o_valid (lane_valid[g])
    );
  end

  assign busy = r_hold_full | (r_idx != '0) | (r_state == SHIFT);

endmodule

// File: tb/tb_tx_lane_striper.sv
// Self-checking bench for tx_lane_striper: lanes are reassembled into byte groups
// and compared against groups built from the bytes sent and the lane-count rule.
module tb_tx_lane_striper;
  import tx_stripe_pkg::*;

  localparam int NL = 4;
  localparam int DW = 8;
  localparam logic [DW-1:0] PAD = 8'hF7;

  typedef struct packed {
    logic [NL-1:0]    mask;
    logic [NL*DW-1:0] data;
  } grp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    lane_mode = 2'd0;
  logic          in_ready, busy;
  logic [NL-1:0] lane_data, lane_valid;

  int n_pass = 0;
  int n_total = 0;
  int stalls = 0;

  logic [DW-1:0] sent_q[$];
  grp_t          exp_q[$];
  grp_t          obs_q[$];

  int               bitpos = 0;
  int               run = 0;
  int               last_run = 0;
  int               viol = 0;
  logic [NL-1:0]    cur_mask = '0;
  logic [NL*DW-1:0] cur_data = '0;

  tx_lane_striper #(.NUM_LANES(NL), .DATA_W(DW), .PAD_BYTE(PAD)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .lane_mode  (lane_mode),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Lane monitor: rebuilds each DATA_W-cycle group from the serial lanes.
  always @(negedge clk) begin
    if (!reset) begin
      bitpos = 0;
      run = 0;
    end else begin
      for (int l = 0; l < NL; l++)
        if (!lane_valid[l] && lane_data[l]) viol++;
      if (lane_valid != '0) begin
        if (bitpos == 0) begin
          cur_mask = lane_valid;
          cur_data = '0;
        end else if (lane_valid != cur_mask) begin
          viol++;
        end
        for (int l = 0; l < NL; l++)
`ifdef TXS_MSB_FIRST_EN
          cur_data[l*DW + (DW-1-bitpos)] = lane_data[l];
`else
          cur_data[l*DW + bitpos] = lane_data[l];
`endif
        bitpos++;
        run++;
        if (bitpos == DW) begin
          obs_q.push_back('{mask: cur_mask, data: cur_data});
          bitpos = 0;
        end
      end else begin
        if (bitpos != 0) viol++;
        bitpos = 0;
        if (run > 0) last_run = run;
        run = 0;
      end
    end
  end

  function automatic int act_of(input logic [1:0] m);
    int n;
    n = 1 << m;
    return (n > NL) ? NL : n;
  endfunction

  // Cut the sent bytes into groups of act, padding a trailing partial group.
  task automatic model_groups(input int act);
    grp_t g;
    while (sent_q.size() > 0) begin
      g = '0;
      for (int k = 0; k < act; k++) begin
        g.mask[k] = 1'b1;
        g.data[k*DW +: DW] = (sent_q.size() > 0) ? sent_q.pop_front() : PAD;
      end
      exp_q.push_back(g);
    end
  endtask

  task automatic send_byte(input logic [DW-1:0] b, input logic fl);
    int n;
    n = 0;
    in_data = b;
    in_valid = 1'b1;
    flush = fl;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    stalls += n;
    if (n >= 200) begin
      n_total++;
      $display("FAIL send_timeout byte %h in_ready %b want 1", b, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    sent_q.push_back(b);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    lane_mode = m;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || lane_valid != '0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      n_total++;
      $display("FAIL idle_timeout busy %b lane_valid %b want 0", busy, lane_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", in_ready); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL release_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (lane_valid !== '0) $display("FAIL reset_valid got %b want 0", lane_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (lane_data !== '0) $display("FAIL reset_data got %b want 0", lane_data); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_x4_stripe();
    int base;
    set_mode(LM_X4);
    base = obs_q.size();
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hD4, 1'b0);
    wait_idle();
    model_groups(act_of(LM_X4));
    n_total++; if (obs_q.size() - base != exp_q.size()) $display("FAIL x4_count got %0d want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
    foreach (exp_q[k]) if (base + k < obs_q.size()) begin
      n_total++; if (obs_q[base+k] !== exp_q[k]) $display("FAIL x4_group%0d got %h want %h", k, obs_q[base+k], exp_q[k]); else n_pass++;
    end
    n_total++; if (last_run != DW) $display("FAIL x4_valid_cycles got %0d want %0d", last_run, DW); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int base, st0;
    set_mode(LM_X4);
    base = obs_q.size();
    st0 = stalls;
    for (int i = 0; i < 16; i++) send_byte(DW'($urandom), 1'b0);
    wait_idle();
    model_groups(act_of(LM_X4));
    n_total++; if (obs_q.size() - base != exp_q.size()) $display("FAIL stream_count got %0d want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
    foreach (exp_q[k]) if (base + k < obs_q.size()) begin
      n_total++; if (obs_q[base+k] !== exp_q[k]) $display("FAIL stream_group%0d got %h want %h", k, obs_q[base+k], exp_q[k]); else n_pass++;
    end
    n_total++; if (last_run != 4 * DW) $display("FAIL stream_run got %0d want %0d", last_run, 4 * DW); else n_pass++;
    n_total++; if (stalls == st0) $display("FAIL stream_backpressure stalls got %0d want >0", stalls - st0); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_flush();
    int base;
    set_mode(LM_X4);
    base = obs_q.size();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    pulse_flush();
    wait_idle();
    model_groups(act_of(LM_X4));
    set_mode(LM_X2);
    send_byte(DW'($urandom), 1'b1);
    wait_idle();
    model_groups(act_of(LM_X2));
    n_total++; if (obs_q.size() - base != exp_q.size()) $display("FAIL flush_count got %0d want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
    foreach (exp_q[k]) if (base + k < obs_q.size()) begin
      n_total++; if (obs_q[base+k] !== exp_q[k]) $display("FAIL flush_group%0d got %h want %h", k, obs_q[base+k], exp_q[k]); else n_pass++;
    end
    exp_q.delete();
    base = obs_q.size();
    pulse_flush();
    n_total++; if (busy !== 1'b0) $display("FAIL empty_flush_busy got %b want 0", busy); else n_pass++;
    repeat (12) @(posedge clk);
    #1;
    n_total++; if (obs_q.size() != base) $display("FAIL empty_flush_groups got %0d want %0d", obs_q.size(), base); else n_pass++;
  endtask

  task automatic test_mode_clamp();
    int base;
    base = obs_q.size();
    set_mode(LM_X8);
    for (int i = 0; i < 4; i++) send_byte(DW'($urandom), 1'b0);
    wait_idle();
    model_groups(act_of(LM_X8));
    send_byte(DW'($urandom), 1'b0);
    send_byte(DW'($urandom), 1'b0);
    lane_mode = LM_X1;
    send_byte(DW'($urandom), 1'b0);
    send_byte(DW'($urandom), 1'b0);
    wait_idle();
    model_groups(act_of(LM_X8));
    for (int i = 0; i < 3; i++) send_byte(DW'($urandom), 1'b0);
    wait_idle();
    model_groups(act_of(LM_X1));
    n_total++; if (obs_q.size() - base != exp_q.size()) $display("FAIL mode_count got %0d want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
    foreach (exp_q[k]) if (base + k < obs_q.size()) begin
      n_total++; if (obs_q[base+k] !== exp_q[k]) $display("FAIL mode_group%0d got %h want %h", k, obs_q[base+k], exp_q[k]); else n_pass++;
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int base, cnt, act;
    logic [1:0] m;
    logic fl_with_last;
    base = obs_q.size();
    for (int r = 0; r < 8; r++) begin
      m = 2'($urandom_range(0, 3));
      cnt = $urandom_range(1, 9);
      fl_with_last = 1'($urandom_range(0, 1));
      act = act_of(m);
      set_mode(m);
      for (int i = 0; i < cnt; i++) begin
        send_byte(DW'($urandom), (i == cnt - 1) && fl_with_last && (cnt % act != 0));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
      if (!fl_with_last && (cnt % act != 0)) pulse_flush();
      wait_idle();
      model_groups(act);
    end
    n_total++; if (obs_q.size() - base != exp_q.size()) $display("FAIL rand_count got %0d want %0d", obs_q.size() - base, exp_q.size()); else n_pass++;
    foreach (exp_q[k]) if (base + k < obs_q.size()) begin
      n_total++; if (obs_q[base+k] !== exp_q[k]) $display("FAIL rand_group%0d got %h want %h", k, obs_q[base+k], exp_q[k]); else n_pass++;
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_shift();
    int base, n;
    set_mode(LM_X4);
    base = obs_q.size();
    for (int i = 0; i < 8; i++) send_byte(DW'($urandom), 1'b0);
    n = 0;
    while (bitpos != 4 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_total++; if (lane_valid !== 4'b1111) $display("FAIL mid_pre_valid got %b want 1111", lane_valid); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (lane_valid !== '0) $display("FAIL mid_rst_valid got %b want 0", lane_valid); else n_pass++;
    n_total++; if (lane_data !== '0) $display("FAIL mid_rst_data got %b want 0", lane_data); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_total++; if (obs_q.size() != base) $display("FAIL mid_discard groups got %0d want %0d", obs_q.size() - base, 0); else n_pass++;
    n_total++; if ({busy, lane_valid} !== '0) $display("FAIL mid_after busy/valid got %b want 0", {busy, lane_valid}); else n_pass++;
    sent_q.delete();
  endtask

  task automatic test_lane_hygiene();
    n_total++; if (viol != 0) $display("FAIL lane_hygiene violations got %0d want 0", viol); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_x4_stripe();
    test_back_to_back();
    test_flush();
    test_mode_clamp();
    test_random();
    test_reset_mid_shift();
    test_lane_hygiene();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tx_lane_striper.md
Name: tx_lane_striper

Overview:
Parametrised PCIe-style transmit striper that takes a byte stream over a valid/ready handshake and distributes bytes round-robin across a run-time selectable number of active lanes. Each active lane has its own serializer, and all lanes start each byte on the same cycle so they stay aligned. This is the single-clock successor of the fixed 4-lane mux/stripe/serialize chain and sits between the link-layer byte source and the lane drivers.

Parameters:
NUM_LANES, 4, physical lane count; power of 2, range 1..8.
DATA_W, 8, symbol width in bits, serialized per lane.
PAD_BYTE, 8'hF7, fill value used for unused lanes of a flushed partial group.

Ports:
clk  in  1  single clock; all logic on the rising edge.
reset  in  1  asynchronous, active-low reset.
in_data  in  DATA_W  byte to stripe.
in_valid  in  1  in_data is valid.
in_ready  out  1  block accepts in_data on this cycle.
flush  in  1  pad and release the partial group.
lane_mode  in  2  active lanes = 2^lane_mode; any value above log2(NUM_LANES) is clamped to NUM_LANES.
lane_data  out  NUM_LANES  serial bit per lane.
lane_valid  out  NUM_LANES  lane carries a valid bit.
busy  out  1  group pending or serializer active.

Behaviour:
- Reset (async assert, sync release): in_ready=0 while reset is asserted and 1 in the first cycle after release. lane_data=0, lane_valid=0, busy=0, idx=0, hold_full=0, act=1 lane.
- Mode latch: act (registered active-lane count) loads from clamped lane_mode only when idx==0, hold_full==0 and the serializer is idle. Otherwise lane_mode is ignored. A mode change never splits a group.
- Collect: in_ready = !hold_full. On accept (in_valid & in_ready): hold[idx] <= in_data. If idx==act-1 then hold_full<=1 and idx<=0, else idx<=idx+1.
- Flush:
  - Takes effect when flush=1 and hold_full=0 and (idx!=0 or an accept occurs this cycle).
  - Any byte accepted in the same cycle is included.
  - Remaining slots up to act-1 are filled with PAD_BYTE, then hold_full<=1 and idx<=0.
  - Flush with an empty group is a no-op.
- Serializer FSM:
  - States: IDLE, SHIFT.
  - Load condition: hold_full and (IDLE, or SHIFT with bit_cnt==DATA_W-1).
  - On load: shift regs for lanes 0..act-1 get hold[0..act-1], hold_full<=0, bit_cnt<=0, state<=SHIFT.
  - In SHIFT: each cycle lane_data[i] = current bit of lane i and lane_valid[i]=1 for i<act.
  - After bit DATA_W-1: reload if a group is pending, otherwise return to IDLE.
- Latency: lane bit 0 appears in the cycle after the load edge. With sustained input, lanes stream with no gap cycles. Throughput is act bytes per DATA_W cycles; in_ready deasserts during backpressure.
- Inactive lanes (i>=act): lane_data=0, lane_valid=0 at all times.
- busy = hold_full | (idx!=0) | (state==SHIFT).
- Bit order: LSB first by default.
- Single lane (act=1): every byte loads lane 0; other lanes stay idle.

Optional Feature:
TXS_MSB_FIRST_EN
- Defined: each lane serializes bit DATA_W-1 first.
- Undefined: LSB first.
- No other behaviour differs.

Decomposition:
- Package tx_stripe_pkg:
  - serializer state enum (IDLE, SHIFT).
  - lane_mode encodings (LM_X1=0, LM_X2=1, LM_X4=2, LM_X8=3).
  - default PAD_BYTE constant.
  - clamp function mode→lane count.
- One natural sub-module, tx_lane_serializer: DATA_W shift register plus valid, with load/shift inputs. Instantiate NUM_LANES copies in a generate loop. bit_cnt and the FSM stay shared in the top level so lanes remain aligned.

Test Plan:
- Reset/idle: hold reset low 3 cycles, release → in_ready=1, lane_valid=0, busy=0, lane_data=0.
- x4 stripe: lane_mode=2; send A1,B2,C3,D4 back-to-back → lanes 0..3 start on the same cycle. Lane0 shows 1,0,0,0,0,1,0,1 (A1 LSB first), lane3 shows D4 bits; lane_valid=4'b1111 for 8 cycles.
- Backpressure/streaming: x4, 16 continuous bytes → in_ready low while hold_full. Lanes carry 32 contiguous valid cycles with no gap; byte order is 0..15 round-robin.
- Flush partial: x4, send 11,22 then flush → lanes 0,1 = 11,22 and lanes 2,3 = F7,F7; busy=0 after 8 lane cycles.
- Mode change and clamp: NUM_LANES=4, lane_mode=3 → behaves as x4. Change to mode 0 mid-group → ignored until the group drains, then lane 0 only and lanes 1..3 stay invalid.
- Async reset mid-shift: assert reset during bit 4 → lane_valid=0 and lane_data=0 immediately; the pending group is discarded.
